// File: rtl/alu_ext_pkg.sv
// Shared opcode map and multiplier FSM state encoding for the alu_ext block.
package alu_ext_pkg;

   // Legacy opcodes: leading 0 followed by the original 4-bit code.
   localparam logic [4:0] CMD_ADAI = 5'b00000;
   localparam logic [4:0] CMD_MVAB = 5'b00001;
   localparam logic [4:0] CMD_INA  = 5'b00010;
   localparam logic [4:0] CMD_MVAI = 5'b00011;
   localparam logic [4:0] CMD_MVBA = 5'b00100;
   localparam logic [4:0] CMD_ADBI = 5'b00101;
   localparam logic [4:0] CMD_INB  = 5'b00110;
   localparam logic [4:0] CMD_MVBI = 5'b00111;
   localparam logic [4:0] CMD_OUTB = 5'b01001;
   localparam logic [4:0] CMD_OUTI = 5'b01011;
   localparam logic [4:0] CMD_JNCI = 5'b01110;
   localparam logic [4:0] CMD_JMPI = 5'b01111;

   // Extended register-register and conditional ops.
   localparam logic [4:0] CMD_ADAB = 5'b10000;
   localparam logic [4:0] CMD_SUAB = 5'b10001;
   localparam logic [4:0] CMD_ANAB = 5'b10010;
   localparam logic [4:0] CMD_ORAB = 5'b10011;
   localparam logic [4:0] CMD_XRAB = 5'b10100;
   localparam logic [4:0] CMD_JCI  = 5'b10101;
   localparam logic [4:0] CMD_JZI  = 5'b10110;
   localparam logic [4:0] CMD_MUL  = 5'b10111;

   // Multiplier sequencer state: IDLE -> RUN -> IDLE.
   typedef logic [0:0] mul_state_t;
   localparam mul_state_t ST_IDLE = 1'b0;
   localparam mul_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/alu_ext_if.sv
// Bus between the decoder/cycle sequencer (master) and the ALU (slave).
//
// Handshake: there is no valid/ready pair. The sequencer presents command and
// operands together with cycle; the ALU acts only on the edge where
// cycle == EXEC_CYCLE and busy == 0, and clears its strobes on the edge where
// cycle == CLEAR_CYCLE. While busy is high the sequencer must hold cycle at
// EXEC_CYCLE; the ALU ignores everything but a clear during that time.
interface alu_ext_if #(
   parameter int WIDTH = 4,
   parameter int CYC_W = 3
);
   // Sequencer -> ALU
   logic [CYC_W-1:0] cycle;
   logic [4:0]       command;
   logic [WIDTH-1:0] immediate;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] in;

   // ALU -> register file / PC
   logic             write_a;
   logic             write_b;
   logic             write_out;
   logic             jump;
   logic             carry_out;
   logic             zero_out;
   logic             busy;
   logic [WIDTH-1:0] data;

   // Multiplier FSM state, exposed for observation.
   alu_ext_pkg::mul_state_t dbg_mul_state;

   modport master (
      output cycle, command, immediate, a, b, in,
      input  write_a, write_b, write_out, jump, carry_out, zero_out, busy, data,
      input  dbg_mul_state
   );

   modport slave (
      input  cycle, command, immediate, a, b, in,
      output write_a, write_b, write_out, jump, carry_out, zero_out, busy, data,
      output dbg_mul_state
   );

endinterface

// File: rtl/alu_seq_mul.sv
// Sequential shift-add multiplier: one partial-product step per clock,
// WIDTH steps per multiply.
//
// done_o is high during the clock whose rising edge commits the final step,
// and product_o carries the product including the step being taken now. That
// lets the parent register the result on the same edge the FSM returns to
// IDLE, so busy lasts exactly WIDTH clocks.
module alu_seq_mul
   import alu_ext_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o,
   output mul_state_t         state_o
);

   localparam int              CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mul_state_t         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] prod_q,   prod_d;
   logic [2*WIDTH-1:0] step_prod;

   // Partial product after adding the shifted multiplicand for the current bit.
   always_comb begin
      step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Next-state logic: latch operands on start, then shift-add until the last step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, a_i};
               mplier_d = b_i;
               prod_d   = '0;
            end
         end
         default: begin
            prod_d   = step_prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // State registers; reset abandons any multiply in flight.
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

   assign busy_o    = (state_q == ST_RUN);
   assign done_o    = (state_q == ST_RUN) && (cnt_q == LAST);
   assign product_o = step_prod;
   assign state_o   = state_q;

endmodule

// File: rtl/alu_ext.sv
// WIDTH-bit ALU between the cycle sequencer and the A/B/OUT registers and PC.
// Single-cycle ops execute on the EXEC_CYCLE edge; MUL runs on the
// sequential multiplier and holds the sequencer off through busy.
module alu_ext
   import alu_ext_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int CYC_W       = 3,
   parameter int EXEC_CYCLE  = 5,
   parameter int CLEAR_CYCLE = 1
) (
   input logic      clk,
   input logic      reset,
   alu_ext_if.slave bus
);

   localparam logic [CYC_W-1:0] EXEC_C  = CYC_W'(EXEC_CYCLE);
   localparam logic [CYC_W-1:0] CLEAR_C = CYC_W'(CLEAR_CYCLE);

   logic [WIDTH-1:0] data_q, data_d;
   logic             write_a_q, write_a_d;
   logic             write_b_q, write_b_d;
   logic             write_out_q, write_out_d;
   logic             jump_q, jump_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             set_zero;

   logic             exec_en;
   logic             clear_en;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] mul_hi;
   mul_state_t       mul_state;

   // WIDTH+1-bit sums so the top bit is the carry (or borrow for subtract).
   logic [WIDTH:0]   sum_ai;
   logic [WIDTH:0]   sum_bi;
   logic [WIDTH:0]   sum_ab;
   logic [WIDTH:0]   diff_ab;

   assign sum_ai  = {1'b0, bus.a} + {1'b0, bus.immediate};
   assign sum_bi  = {1'b0, bus.b} + {1'b0, bus.immediate};
   assign sum_ab  = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_ab = {1'b0, bus.a} - {1'b0, bus.b};

   // A busy multiplier blocks re-execution even with cycle parked at EXEC.
   assign exec_en   = (bus.cycle == EXEC_C) && !mul_busy;
   assign clear_en  = (bus.cycle == CLEAR_C);
   assign mul_start = reset && exec_en && (bus.command == CMD_MUL);

   assign mul_lo = mul_product[WIDTH-1:0];
   assign mul_hi = mul_product[2*WIDTH-1:WIDTH];

   alu_seq_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_ni    (reset),
      .start_i   (mul_start),
      .a_i       (bus.a),
      .b_i       (bus.b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product),
      .state_o   (mul_state)
   );

   // Decode the command into the values registered on an execute edge.
   always_comb begin
      data_d      = '0;
      write_a_d   = 1'b0;
      write_b_d   = 1'b0;
      write_out_d = 1'b0;
      jump_d      = 1'b0;
      carry_d     = carry_q;
      set_zero    = 1'b0;
      case (bus.command)
         CMD_ADAI: begin {carry_d, data_d} = sum_ai; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_MVAB: begin data_d = bus.b;         write_a_d   = 1'b1; end
         CMD_INA:  begin data_d = bus.in;        write_a_d   = 1'b1; end
         CMD_MVAI: begin data_d = bus.immediate; write_a_d   = 1'b1; end
         CMD_MVBA: begin data_d = bus.a;         write_b_d   = 1'b1; end
         CMD_ADBI: begin {carry_d, data_d} = sum_bi; write_b_d = 1'b1; set_zero = 1'b1; end
         CMD_INB:  begin data_d = bus.in;        write_b_d   = 1'b1; end
         CMD_MVBI: begin data_d = bus.immediate; write_b_d   = 1'b1; end
         CMD_OUTB: begin data_d = bus.b;         write_out_d = 1'b1; end
         CMD_OUTI: begin data_d = bus.immediate; write_out_d = 1'b1; end
         CMD_JNCI: begin data_d = bus.immediate; jump_d = !carry_q; end
         CMD_JMPI: begin data_d = bus.immediate; jump_d = 1'b1; end
         CMD_ADAB: begin {carry_d, data_d} = sum_ab; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_SUAB: begin {carry_d, data_d} = diff_ab; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_ANAB: begin data_d = bus.a & bus.b; carry_d = 1'b0; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_ORAB: begin data_d = bus.a | bus.b; carry_d = 1'b0; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_XRAB: begin data_d = bus.a ^ bus.b; carry_d = 1'b0; write_a_d = 1'b1; set_zero = 1'b1; end
         CMD_JCI:  begin data_d = bus.immediate; jump_d = carry_q; end
         CMD_JZI:  begin data_d = bus.immediate; jump_d = zero_q; end
         // Start edge: strobes drop, data and flags wait for the product.
         CMD_MUL:  begin data_d = data_q; end
         default:  begin data_d = '0; end
      endcase
      zero_d = set_zero ? (data_d == '0) : zero_q;
   end

   // Output registers. Reset beats everything; a finishing multiply beats a
   // clear so the product write is never lost; execute and clear are exclusive.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q      <= '0;
         write_a_q   <= 1'b0;
         write_b_q   <= 1'b0;
         write_out_q <= 1'b0;
         jump_q      <= 1'b0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
      end else if (mul_done) begin
         data_q      <= mul_lo;
         write_a_q   <= 1'b1;
         write_b_q   <= 1'b0;
         write_out_q <= 1'b0;
         jump_q      <= 1'b0;
         carry_q     <= |mul_hi;
         zero_q      <= (mul_lo == '0);
      end else if (exec_en) begin
         data_q      <= data_d;
         write_a_q   <= write_a_d;
         write_b_q   <= write_b_d;
         write_out_q <= write_out_d;
         jump_q      <= jump_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
      end else if (clear_en) begin
         write_a_q   <= 1'b0;
         write_b_q   <= 1'b0;
         write_out_q <= 1'b0;
         jump_q      <= 1'b0;
      end
   end

   assign bus.data          = data_q;
   assign bus.write_a       = write_a_q;
   assign bus.write_b       = write_b_q;
   assign bus.write_out     = write_out_q;
   assign bus.jump          = jump_q;
   assign bus.carry_out     = carry_q;
   assign bus.zero_out      = zero_q;
   assign bus.busy          = mul_busy;
   assign bus.dbg_mul_state = mul_state;

endmodule

// File: doc/alu_ext.md
# alu_ext

Parametrised successor to the miniTB04 ALU: same cycle-gated execute/clear scheme and A/B/OUT/jump write-strobe interface, generalised to a WIDTH-bit datapath. It adds a stored zero flag, register-register arithmetic and logic ops, carry- and zero-conditional jumps, and a multi-cycle shift-add multiply that stalls the cycle sequencer through `busy`. It sits between the decoder/cycle sequencer and the A/B/OUT registers and PC.

## Interface
- `WIDTH`, 4: datapath, immediate and register width (≥2).
- `CYC_W`, 3: width of `cycle`.
- `EXEC_CYCLE`, 5: cycle value on which a command executes.
- `CLEAR_CYCLE`, 1: cycle value on which write/jump strobes clear; must differ from `EXEC_CYCLE`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `cycle` in CYC_W: sequencer phase.
- `command` in 5: opcode.
- `immediate`, `a`, `b`, `in` in WIDTH each: operands.
- `write_a`, `write_b`, `write_out`, `jump` out 1: registered destination strobes.
- `carry_out`, `zero_out` out 1: stored C and Z flags.
- `busy` out 1: multiply in progress; sequencer holds `cycle` at EXEC_CYCLE while high.
- `data` out WIDTH: result / jump target.

## Operation
- Legacy opcodes (`0` prefix + the miniTB04 4-bit code): ADAI 00000, MVAB 00001, INA 00010, MVAI 00011, MVBA 00100, ADBI 00101, INB 00110, MVBI 00111, OUTB 01001, OUTI 01011, JNCI 01110, JMPI 01111. Same semantics, widened to WIDTH.
- New ops: ADAB 10000 (A=A+B), SUAB 10001 (A=A−B), ANAB 10010, ORAB 10011, XRAB 10100 (A=A op B), JCI 10101 (jump if C=1), JZI 10110 (jump if Z=1), MUL 10111 (A=low WIDTH bits of A×B).
- Add: {C,data}=op1+op2 at WIDTH+1 bits. SUAB: data=(a−b) mod 2^WIDTH, C=1 iff a<b (borrow).
- Logic ops: C←0.
- Z←(data==0) on every add, sub, logic and MUL result. MOV/IN/OUT/jumps leave C and Z unchanged.
- Jumps: data=immediate; jump=1 only if the condition holds. A jump whose condition fails still drives data=immediate.
- Undefined opcodes: all strobes 0, data=0, flags held.
- MUL FSM, states IDLE → RUN → IDLE:
  - Start at execute: latch a, b; clear the 2·WIDTH-bit product and the iteration counter; busy←1.
  - Each RUN clock: one shift-add step.
  - After WIDTH steps: data=product[WIDTH-1:0], write_a←1, C←|product[2W-1:W], Z←(data==0), busy←0.

## Timing
- Execute edge: rising `clk` with `reset`=1, `cycle`==EXEC_CYCLE and `busy`=0. Strobes, data and flags are registered on that edge and visible after it; one-clock latency.
- While `busy`=1, `cycle`==EXEC_CYCLE does not re-execute. Other inputs are ignored except `cycle`==CLEAR_CYCLE.
- Clear edge (`cycle`==CLEAR_CYCLE): write_a/b/out and jump ←0. Data and flags are held. Strobes otherwise persist between execute and clear.
- MUL: busy is high for exactly WIDTH clocks after the start edge. The result and write_a appear on the WIDTH-th edge after start. write_a stays 0 during RUN.
- Reset (`reset`=0 at an edge): all outputs, C, Z and busy ←0; FSM ←IDLE; an in-flight MUL is aborted with no write.
- A reset edge overrides any simultaneous execute, clear or MUL completion.

## Structure
- Package `alu_ext_pkg`:
  - 5-bit opcode localparams (CMD_*).
  - FSM state typedef {IDLE, RUN}.
- Sub-module `alu_seq_mul` (parameter WIDTH): start/operand inputs; busy, done and 2·WIDTH product outputs; WIDTH-cycle shift-add.
- Top level holds the combinational next-value decode, flag registers and strobe registers.

## Test plan
- WIDTH=4, ADAI a=0xC imm=0x5 at EXEC_CYCLE → data=0x1, write_a=1, C=1, Z=0. Then JNCI imm=0x7 → jump=0, data=0x7. Then JCI imm=0x7 → jump=1.
- SUAB a=3 b=5 → data=0xE, C=1. Then SUAB a=5 b=5 → data=0, C=0, Z=1. Then JZI imm=2 → jump=1. At CLEAR_CYCLE → all strobes 0, data still 2.
- MUL a=7 b=5 (WIDTH=4) → busy high exactly 4 clocks; then data=0x3, C=1, write_a=1. MUL a=3 b=5 → data=0xF, C=0.
- Hold cycle=EXEC_CYCLE during MUL with command changed to MVAI imm=9 → no extra execute; result matches the first MUL only.
- Assert reset low two clocks into a MUL → busy=0, write_a=0, C=0, Z=0, data=0. No write after reset release.
- WIDTH=8: ADAB a=0xF0 b=0x20 → data=0x10, C=1. MUL 0x10×0x10 → data=0x00, C=1, Z=1, busy 8 clocks. Undefined opcode 11111 → strobes 0, flags unchanged.
